sha3_msg_arbiter: RTL and testbench
===================================

Name: sha3_msg_arbiter

Overview:
- Shares one SHA3 absorb path (padder plus permutation core) between NUM_REQ independent message sources.
- Grants the path to one requester for a whole message, from the first word through the final digest.
- Forwards that requester's 64-bit words, byte_num and is_last to the padder, and returns per-source backpressure and completion.
- Sits between the host-side stream adapters and the padder input.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 1, width of the owner index; equals clog2(NUM_REQ), minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-source message request, level, held for the whole message
- src_in  in  64*NUM_REQ  per-source data word; source i occupies bits [64i+63:64i]
- src_byte_num  in  3*NUM_REQ  per-source valid byte count of the last word
- src_in_ready  in  NUM_REQ  per-source word valid
- src_is_last  in  NUM_REQ  per-source last-word flag, qualified by src_in_ready
- src_buffer_full  out  NUM_REQ  per-source stall; a word is accepted only while this bit is 0
- gnt  out  NUM_REQ  one-hot grant, registered
- done  out  NUM_REQ  one-cycle pulse: digest for that source is valid on the core output
- core_in  out  64  word to padder
- core_byte_num  out  3  to padder
- core_in_ready  out  1  to padder
- core_is_last  out  1  to padder
- core_buffer_full  in  1  padder backpressure
- core_out_ready  in  1  digest-valid level from the permutation core
- owner  out  ID_W  index of the current or last grantee
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky protocol-error flag, cleared only by reset

Behaviour:
- Reset values:
  - gnt=0, done=0, owner=0, busy=0, err=0.
  - core_in_ready=0, core_is_last=0, core_in=0, core_byte_num=0.
  - src_buffer_full all ones.
  - Round-robin pointer = 0; state = IDLE.
  - Reset is honoured in any state. An in-flight message is abandoned and no done pulse is issued.
- FSM states: IDLE, GRANT, ABSORB, WAIT_HASH.
- IDLE:
  - If any req bit is set, choose the winner round-robin, starting the search at the pointer.
  - Register gnt and owner, then go to GRANT.
- GRANT: one cycle, lets the winner observe gnt. Then go to ABSORB.
- ABSORB:
  - Combinational mux of the owner's src_* fields onto core_*.
  - core_in_ready = src_in_ready[owner].
  - src_buffer_full[owner] = core_buffer_full; all other bits are 1.
  - A word is accepted when src_in_ready[owner]=1 and core_buffer_full=0.
  - When the accepted word has src_is_last=1, go to WAIT_HASH.
- WAIT_HASH:
  - core_in_ready=0 and all src_buffer_full bits are 1.
  - Track core_out_ready. On its rising edge (0->1), pulse done[owner] for one cycle.
  - In that same cycle: clear gnt, set pointer = owner+1 (wrapping to 0 at NUM_REQ), go to IDLE.
  - owner holds its value in IDLE so the consumer can tag the digest.
- Outside ABSORB, core_in, core_byte_num and core_is_last are 0.
- Latency:
  - req to gnt: 2 cycles (IDLE, then GRANT).
  - First word can be accepted in the 3rd cycle after req rises.
  - Last-word acceptance to done: the core latency plus 1 cycle.
- Simultaneous requests: round-robin only. A requester that is denied wins within NUM_REQ arbitrations.
- Request behaviour during a message:
  - req[owner] dropping during GRANT, ABSORB or WAIT_HASH sets err; the message still completes.
  - New req edges from other sources are ignored until IDLE.
- Back-to-back traffic: the next grant takes 2 cycles after done (IDLE, then GRANT). This gap is fixed.
- src_in_ready from a non-owner: ignored, never forwarded.
- A non-owner asserting src_in_ready with src_is_last=1 sets err.

Decomposition:
- Package sha3_arb_pkg holds:
  - the state enum (IDLE, GRANT, ABSORB, WAIT_HASH);
  - the default NUM_REQ;
  - the word width 64 and byte_num width 3;
  - an onehot-to-index function.
- One sub-module, rr_arbiter:
  - parameter N;
  - inputs: req, pointer, enable;
  - outputs: one-hot grant and index;
  - purely combinational, instantiated once.

Test Plan:
- Single source: req[0]=1, words 0x0011223344556677 and then 0xAABBCCDDEEFF0000 with is_last=1, byte_num=3.
  - gnt=01 two cycles after req rises.
  - core_in sees both words in order.
  - core_is_last=1 with core_byte_num=3.
  - Pulse core_out_ready -> done=01 for one cycle, owner=0.
- Contention: req=11 in the same cycle from reset.
  - Source 0 is served first, then source 1.
  - Second grant follows done[0] by exactly 2 cycles, owner=1.
  - A third contention is won by source 0.
- Backpressure: hold core_buffer_full=1 for 17 cycles mid-message.
  - No word accepted, src_buffer_full[0]=1.
  - Words resume unchanged after release; no word is duplicated or dropped.
- Non-owner isolation: source 1 drives src_in_ready=1 with src_is_last=1 during source 0's ABSORB.
  - core_in_ready follows source 0 only.
  - err=1; source 0's message completes normally.
- Reset mid-ABSORB: assert reset after 5 words.
  - All outputs return to reset values in the same cycle.
  - No done pulse is issued.
  - Next req=10 is granted to source 1.
- Owner drops req in WAIT_HASH -> err=1 and done still pulses after core_out_ready.

Source files
------------

// File: rtl/sha3_arb_pkg.sv
// Shared types and constants for the SHA3 message arbiter: FSM encoding,
// datapath widths and a one-hot decode helper.
package sha3_arb_pkg;

  localparam int NUM_REQ_DEF = 2;
  localparam int WORD_W      = 64;
  localparam int BN_W        = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT     = 2'd1,
    ST_ABSORB    = 2'd2,
    ST_WAIT_HASH = 2'd3
  } arb_state_e;

  // Supports up to eight requesters; callers zero-extend narrower vectors.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sha3_msg_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after pointer,
// wrapping around, reported both one-hot and as an index.
module rr_arbiter
  import sha3_arb_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] pointer,
  input  logic         enable,
  output logic [N-1:0] grant,
  output logic [W-1:0] index
);

  logic [2*N-1:0] req_dbl;
  logic           found;

  assign req_dbl = {req, req};

  // Scanning the doubled vector from pointer upward visits every source
  // exactly once in rotated order before any position repeats.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < 2 * N; k++) begin
      if (enable && !found && (k >= int'(pointer)) && req_dbl[k]) begin
        grant[k % N] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign index = W'(onehot_to_idx(8'(grant)));

endmodule

// File: rtl/sha3_msg_arbiter.sv
// Shares one SHA3 padder/permutation path between NUM_REQ message sources,
// holding the grant from the first word until the digest is reported.
module sha3_msg_arbiter
  import sha3_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [64*NUM_REQ-1:0]   src_in,
  input  logic [3*NUM_REQ-1:0]    src_byte_num,
  input  logic [NUM_REQ-1:0]      src_in_ready,
  input  logic [NUM_REQ-1:0]      src_is_last,
  output logic [NUM_REQ-1:0]      src_buffer_full,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic [63:0]             core_in,
  output logic [2:0]              core_byte_num,
  output logic                    core_in_ready,
  output logic                    core_is_last,
  input  logic                    core_buffer_full,
  input  logic                    core_out_ready,
  output logic [ID_W-1:0]         owner,
  output logic                    busy,
  output logic                    err
);

  localparam logic [1:0] IDLE      = ST_IDLE;
  localparam logic [1:0] GRANT     = ST_GRANT;
  localparam logic [1:0] ABSORB    = ST_ABSORB;
  localparam logic [1:0] WAIT_HASH = ST_WAIT_HASH;

  logic [1:0]         state_reg, state_next;
  logic [ID_W-1:0]    owner_reg, owner_next;
  logic [ID_W-1:0]    ptr_reg, ptr_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic               err_reg, err_next;
  logic               cor_prev_reg;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_index;
  logic [WORD_W-1:0]  word_arr [NUM_REQ];
  logic [BN_W-1:0]    bn_arr   [NUM_REQ];

  logic in_absorb;
  logic last_accept;
  logic cor_rise;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_src
      assign word_arr[gi] = src_in[gi*WORD_W +: WORD_W];
      assign bn_arr[gi]   = src_byte_num[gi*BN_W +: BN_W];
    end
  endgenerate

  rr_arbiter #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_rr (
    .req     (req),
    .pointer (ptr_reg),
    .enable  (state_reg == IDLE),
    .grant   (arb_grant),
    .index   (arb_index)
  );

  assign in_absorb   = (state_reg == ABSORB);
  assign last_accept = in_absorb && src_in_ready[owner_reg] && !core_buffer_full
                       && src_is_last[owner_reg];
  assign cor_rise    = core_out_ready && !cor_prev_reg;

  // Only the owner's lanes ever reach the padder; every other source is stalled.
  always_comb begin
    core_in         = '0;
    core_byte_num   = '0;
    core_in_ready   = 1'b0;
    core_is_last    = 1'b0;
    src_buffer_full = '1;
    if (in_absorb) begin
      core_in                    = word_arr[owner_reg];
      core_byte_num              = bn_arr[owner_reg];
      core_in_ready              = src_in_ready[owner_reg];
      core_is_last               = src_is_last[owner_reg];
      src_buffer_full[owner_reg] = core_buffer_full;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    gnt_next   = gnt_reg;
    done_next  = '0;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          gnt_next   = arb_grant;
          owner_next = arb_index;
          state_next = GRANT;
        end
      end
      GRANT:  state_next = ABSORB;
      ABSORB: if (last_accept) state_next = WAIT_HASH;
      WAIT_HASH: begin
        if (cor_rise) begin
          done_next  = gnt_reg;
          gnt_next   = '0;
          ptr_next   = (owner_reg == ID_W'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // gnt_reg is one-hot on the owner while a message is in flight.
    if (state_reg != IDLE) begin
      if (!req[owner_reg]) err_next = 1'b1;
      if (|(src_in_ready & src_is_last & ~gnt_reg)) err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      ptr_reg      <= '0;
      gnt_reg      <= '0;
      done_reg     <= '0;
      err_reg      <= 1'b0;
      cor_prev_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      ptr_reg      <= ptr_next;
      gnt_reg      <= gnt_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      cor_prev_reg <= core_out_ready;
    end
  end

  assign gnt   = gnt_reg;
  assign done  = done_reg;
  assign owner = owner_reg;
  assign busy  = (state_reg != IDLE);
  assign err   = err_reg;

endmodule

// File: tb/tb_sha3_msg_arbiter.sv
// Directed bench for sha3_msg_arbiter: a per-cycle vector table for a single
// message, then hand-written contention, stall, isolation and reset sequences.
module tb_sha3_msg_arbiter;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [64*N-1:0] src_in = '0;
  logic [3*N-1:0] src_byte_num = '0;
  logic [N-1:0]   src_in_ready = '0;
  logic [N-1:0]   src_is_last = '0;
  logic [N-1:0]   src_buffer_full;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [63:0]    core_in;
  logic [2:0]     core_byte_num;
  logic           core_in_ready;
  logic           core_is_last;
  logic           core_buffer_full = 1'b0;
  logic           core_out_ready = 1'b0;
  logic [0:0]     owner;
  logic           busy;
  logic           err;

  int errors = 0;
  int checks = 0;
  logic [63:0] acc_log[$];

  sha3_msg_arbiter #(.NUM_REQ(N), .ID_W(1)) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .src_in           (src_in),
    .src_byte_num     (src_byte_num),
    .src_in_ready     (src_in_ready),
    .src_is_last      (src_is_last),
    .src_buffer_full  (src_buffer_full),
    .gnt              (gnt),
    .done             (done),
    .core_in          (core_in),
    .core_byte_num    (core_byte_num),
    .core_in_ready    (core_in_ready),
    .core_is_last     (core_is_last),
    .core_buffer_full (core_buffer_full),
    .core_out_ready   (core_out_ready),
    .owner            (owner),
    .busy             (busy),
    .err              (err)
  );

  always #5 clk = ~clk;

  // Words the padder actually takes: valid and not stalled at the clock edge.
  always @(posedge clk) begin
    if (!reset && core_in_ready && !core_buffer_full) acc_log.push_back(core_in);
  end

  typedef struct {
    logic [1:0]  req, rdy, last;
    logic [2:0]  bn;
    logic [63:0] w;
    logic        cor;
    logic [1:0]  e_gnt, e_done, e_sbf;
    logic        e_busy, e_cir, e_clast;
    logic [63:0] e_cin;
    logic [2:0]  e_cbn;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s = %h", nm, act);
    end
  endtask

  task automatic clear_inputs();
    req = '0; src_in = '0; src_byte_num = '0; src_in_ready = '0; src_is_last = '0;
    core_buffer_full = 1'b0; core_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_word(input int s, input logic [63:0] w, input logic last,
                           input logic [2:0] bn);
    logic ok;
    ok = 1'b0;
    src_in[s*64 +: 64]    = w;
    src_byte_num[s*3 +: 3] = bn;
    src_is_last[s]        = last;
    src_in_ready[s]       = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      #1;
      if (!src_buffer_full[s]) ok = 1'b1;
      tick();
    end
    src_in_ready[s] = 1'b0;
    src_is_last[s]  = 1'b0;
    src_in[s*64 +: 64] = '0;
    chk($sformatf("accept_src%0d", s), 64'(ok), 64'd1);
  endtask

  // Enters with the last word already taken; raises core_out_ready and checks
  // the single done pulse, applying next_req in the done cycle.
  task automatic finish_msg(input int s, input logic [1:0] next_req);
    tick();
    core_out_ready = 1'b1;
    tick();
    core_out_ready = 1'b0;
    #1;
    chk($sformatf("done_src%0d", s), 64'(done), 64'(1 << s));
    chk("done_owner", 64'(owner), 64'(s));
    chk("done_gnt_clear", 64'(gnt), 64'd0);
    chk("done_busy", 64'(busy), 64'd0);
    req = next_req;
    tick();
    #1;
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  function automatic vec_t mk(logic [1:0] rq, logic [1:0] rdy, logic [1:0] last,
                              logic [2:0] bn, logic [63:0] w, logic cor,
                              logic [1:0] eg, logic [1:0] ed, logic [1:0] es,
                              logic eb, logic ec, logic el, logic [63:0] ei,
                              logic [2:0] en);
    vec_t v;
    v.req = rq; v.rdy = rdy; v.last = last; v.bn = bn; v.w = w; v.cor = cor;
    v.e_gnt = eg; v.e_done = ed; v.e_sbf = es; v.e_busy = eb; v.e_cir = ec;
    v.e_clast = el; v.e_cin = ei; v.e_cbn = en;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] w0, w1;
    w0 = 64'h0011223344556677;
    w1 = 64'hAABBCCDDEEFF0000;
    //             req    rdy    last   bn    word cor  gnt    done   sbf   busy cir last cin  cbn
    vecs[0] = mk(2'b01, 2'b00, 2'b00, 3'd0, 64'd0, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 64'd0, 3'd0);
    vecs[1] = mk(2'b01, 2'b00, 2'b00, 3'd0, 64'd0, 0, 2'b01, 2'b00, 2'b11, 1, 0, 0, 64'd0, 3'd0);
    vecs[2] = mk(2'b01, 2'b01, 2'b00, 3'd0, w0,    0, 2'b01, 2'b00, 2'b10, 1, 1, 0, w0,    3'd0);
    vecs[3] = mk(2'b01, 2'b01, 2'b01, 3'd3, w1,    0, 2'b01, 2'b00, 2'b10, 1, 1, 1, w1,    3'd3);
    vecs[4] = mk(2'b01, 2'b00, 2'b00, 3'd0, 64'd0, 0, 2'b01, 2'b00, 2'b11, 1, 0, 0, 64'd0, 3'd0);
    vecs[5] = mk(2'b01, 2'b00, 2'b00, 3'd0, 64'd0, 1, 2'b01, 2'b00, 2'b11, 1, 0, 0, 64'd0, 3'd0);
    vecs[6] = mk(2'b00, 2'b00, 2'b00, 3'd0, 64'd0, 0, 2'b00, 2'b01, 2'b11, 0, 0, 0, 64'd0, 3'd0);
    vecs[7] = mk(2'b00, 2'b00, 2'b00, 3'd0, 64'd0, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 64'd0, 3'd0);

    // Reset state.
    clear_inputs();
    reset = 1'b1;
    tick();
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_sbf", 64'(src_buffer_full), 64'h3);
    chk("rst_cir", 64'(core_in_ready), 64'd0);
    do_reset();

    // Single source, one row per clock cycle.
    for (int i = 0; i < 8; i++) begin
      req = vecs[i].req;
      src_in_ready = vecs[i].rdy;
      src_is_last = vecs[i].last;
      src_byte_num = {3'd0, vecs[i].bn};
      src_in = {64'd0, vecs[i].w};
      core_out_ready = vecs[i].cor;
      #1;
      chk($sformatf("v%0d_gnt", i), 64'(gnt), 64'(vecs[i].e_gnt));
      chk($sformatf("v%0d_done", i), 64'(done), 64'(vecs[i].e_done));
      chk($sformatf("v%0d_sbf", i), 64'(src_buffer_full), 64'(vecs[i].e_sbf));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
      chk($sformatf("v%0d_cir", i), 64'(core_in_ready), 64'(vecs[i].e_cir));
      chk($sformatf("v%0d_clast", i), 64'(core_is_last), 64'(vecs[i].e_clast));
      chk($sformatf("v%0d_cin", i), core_in, vecs[i].e_cin);
      chk($sformatf("v%0d_cbn", i), 64'(core_byte_num), 64'(vecs[i].e_cbn));
      chk($sformatf("v%0d_owner", i), 64'(owner), 64'd0);
      chk($sformatf("v%0d_err", i), 64'(err), 64'd0);
      tick();
    end
    clear_inputs();

    // Contention from reset: 0 then 1, then 0 again.
    do_reset();
    req = 2'b11;
    tick();
    #1;
    chk("cont_first_gnt", 64'(gnt), 64'd1);
    send_word(0, 64'h1111000011110000, 1'b1, 3'd1);
    finish_msg(0, 2'b10);
    chk("cont_second_gnt", 64'(gnt), 64'd2);
    chk("cont_second_owner", 64'(owner), 64'd1);
    send_word(1, 64'h2222000022220000, 1'b1, 3'd2);
    finish_msg(1, 2'b11);
    chk("cont_third_gnt", 64'(gnt), 64'd1);
    chk("cont_third_owner", 64'(owner), 64'd0);
    send_word(0, 64'h3333000033330000, 1'b1, 3'd4);
    finish_msg(0, 2'b00);
    chk("cont_err", 64'(err), 64'd0);

    // Backpressure: 17-cycle stall in the middle of a four-word message.
    do_reset();
    acc_log.delete();
    req = 2'b01;
    send_word(0, 64'hB0B0B0B0B0B0B0B0, 1'b0, 3'd0);
    send_word(0, 64'hB1B1B1B1B1B1B1B1, 1'b0, 3'd0);
    core_buffer_full = 1'b1;
    src_in[63:0] = 64'hB2B2B2B2B2B2B2B2;
    src_in_ready[0] = 1'b1;
    for (int c = 0; c < 17; c++) begin
      #1;
      chk($sformatf("stall%0d_sbf0", c), 64'(src_buffer_full[0]), 64'd1);
      tick();
    end
    chk("stall_no_accept", 64'(acc_log.size()), 64'd2);
    core_buffer_full = 1'b0;
    send_word(0, 64'hB2B2B2B2B2B2B2B2, 1'b0, 3'd0);
    send_word(0, 64'hB3B3B3B3B3B3B3B3, 1'b1, 3'd5);
    finish_msg(0, 2'b00);
    chk("bp_count", 64'(acc_log.size()), 64'd4);
    for (int k = 0; k < 4 && k < acc_log.size(); k++) begin
      logic [63:0] exp_w;
      exp_w = {8{8'hB0 + 8'(k)}};
      chk($sformatf("bp_word%0d", k), acc_log[k], exp_w);
    end

    // Non-owner isolation during source 0's message.
    do_reset();
    acc_log.delete();
    req = 2'b01;
    tick();
    tick();
    src_in[127:64] = 64'hDEADBEEFDEADBEEF;
    src_is_last[1] = 1'b1;
    src_in_ready[1] = 1'b1;
    #1;
    chk("iso_cir", 64'(core_in_ready), 64'd0);
    chk("iso_clast", 64'(core_is_last), 64'd0);
    chk("iso_cin", core_in, 64'd0);
    chk("iso_sbf", 64'(src_buffer_full), 64'h2);
    tick();
    #1;
    chk("iso_err", 64'(err), 64'd1);
    send_word(0, 64'hC0C0C0C0C0C0C0C0, 1'b0, 3'd0);
    send_word(0, 64'hC1C1C1C1C1C1C1C1, 1'b1, 3'd7);
    finish_msg(0, 2'b00);
    chk("iso_count", 64'(acc_log.size()), 64'd2);
    if (acc_log.size() == 2) begin
      chk("iso_word0", acc_log[0], 64'hC0C0C0C0C0C0C0C0);
      chk("iso_word1", acc_log[1], 64'hC1C1C1C1C1C1C1C1);
    end
    chk("iso_err_sticky", 64'(err), 64'd1);
    clear_inputs();

    // Reset in the middle of ABSORB after five words.
    req = 2'b01;
    for (int k = 0; k < 5; k++) send_word(0, 64'(k + 1), 1'b0, 3'd0);
    src_in[63:0] = 64'h6;
    src_in_ready[0] = 1'b1;
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", 64'(gnt), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_err", 64'(err), 64'd0);
    chk("mid_rst_owner", 64'(owner), 64'd0);
    chk("mid_rst_cir", 64'(core_in_ready), 64'd0);
    chk("mid_rst_cin", core_in, 64'd0);
    chk("mid_rst_sbf", 64'(src_buffer_full), 64'h3);
    core_out_ready = 1'b1;
    tick();
    core_out_ready = 1'b0;
    tick();
    #1;
    chk("mid_rst_no_done", 64'(done), 64'd0);
    clear_inputs();
    reset = 1'b0;
    req = 2'b10;
    tick();
    #1;
    chk("post_rst_done", 64'(done), 64'd0);
    chk("post_rst_gnt", 64'(gnt), 64'd2);
    chk("post_rst_owner", 64'(owner), 64'd1);
    send_word(1, 64'h7777777777777777, 1'b1, 3'd2);
    finish_msg(1, 2'b00);

    // Owner drops req while waiting for the digest.
    req = 2'b01;
    send_word(0, 64'h8888888888888888, 1'b1, 3'd1);
    #1;
    chk("drop_err_before", 64'(err), 64'd0);
    req = 2'b00;
    tick();
    #1;
    chk("drop_err_after", 64'(err), 64'd1);
    finish_msg(0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
